// File: rtl/beam_pkg.sv
// Shared types for the transmit beam sweep scheduler.
// Default widths match the sin_lut and the transmit delay bank.
package beam_pkg;

  localparam int ANGLE_W = 8;
  localparam int DELAY_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPUTE,
    EMIT,
    FIRE,
    DWELL
  } beam_state_t;

  typedef logic signed [ANGLE_W-1:0] angle_t;
  typedef logic [DELAY_W-1:0]        delay_t;

endpackage

// File: rtl/dwell_timer.sv
// Echo-window counter: load clears it, en counts up,
// and done flags the final cycle 0..LIMIT-1.
module dwell_timer
  import beam_pkg::*;
#(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_in,
  input  logic en_in,
  output logic done_out
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || load_in) begin
      cnt_q <= '0;
    end else if (en_in) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done_out = en_in && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/beam_steer_scheduler.sv
// Transmit beam sweep: lookup, delay emit, fire, dwell per angle.
// Define BEAM_PINGPONG_EN to reverse at the range ends instead of wrapping.
module beam_steer_scheduler
  import beam_pkg::*;
#(
  parameter int NUM_ELEMENTS = 4,
  parameter int ANGLE_WIDTH  = 8,
  parameter int SIN_WIDTH    = 16,
  parameter int DELAY_WIDTH  = 16,
  parameter int PITCH_CYCLES = 54,
  parameter int ANGLE_MIN    = -60,
  parameter int ANGLE_MAX    = 60,
  parameter int ANGLE_STEP   = 5,
  parameter int DWELL_CYCLES = 1_000_000
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic                            stop_in,
  output logic signed [ANGLE_WIDTH-1:0]   angle_out,
  input  logic [SIN_WIDTH-1:0]            sin_value_in,
  input  logic                            sign_bit_in,
  output logic [DELAY_WIDTH-1:0]          delay_out,
  output logic [$clog2(NUM_ELEMENTS)-1:0] delay_idx_out,
  output logic                            delay_valid_out,
  input  logic                            delay_ready_in,
  output logic                            burst_trigger_out,
  output logic signed [ANGLE_WIDTH-1:0]   sweep_angle_out,
  output logic                            busy_out,
  output logic                            sweep_done_out
);

  localparam int AW     = ANGLE_WIDTH;
  localparam int IDX_W  = $clog2(NUM_ELEMENTS);
  localparam int PROD_W = SIN_WIDTH + $clog2(PITCH_CYCLES + 1);

  localparam logic signed [AW:0] MIN_X  = (AW+1)'(ANGLE_MIN);
  localparam logic signed [AW:0] MAX_X  = (AW+1)'(ANGLE_MAX);
  localparam logic signed [AW:0] STEP_X = (AW+1)'(ANGLE_STEP);

  beam_state_t state_q, state_d;

  logic signed [AW-1:0]   angle_q;
  logic [SIN_WIDTH-1:0]   sin_q;
  logic                   sign_q;
  logic [DELAY_WIDTH-1:0] mag_q;
  logic [DELAY_WIDTH-1:0] acc_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   stop_pend_q;
  logic                   done_q;

  logic                   accept;
  logic                   last;
  logic                   abort;
  logic                   advance;
  logic                   dwell_done;
  logic                   wrap;
  logic signed [AW:0]     angle_x;
  logic signed [AW:0]     angle_nx;
  logic [PROD_W-1:0]      prod;
  logic [DELAY_WIDTH-1:0] mag_d;

  assign accept  = (state_q == EMIT) && delay_ready_in;
  assign last    = idx_q == IDX_W'(NUM_ELEMENTS - 1);
  assign abort   = (state_q != IDLE) && (state_d == IDLE);
  assign advance = (state_q == DWELL) && (state_d == LOOKUP);
  assign angle_x = {angle_q[AW-1], angle_q};

  // Full product kept so the shift drops only fractional bits.
  assign prod  = PROD_W'(sin_q) * PROD_W'(PITCH_CYCLES);
  assign mag_d = DELAY_WIDTH'(prod >> SIN_WIDTH);

`ifdef BEAM_PINGPONG_EN
  logic               dir_q;
  logic signed [AW:0] fwd;
  logic signed [AW:0] rev;

  always_comb begin
    fwd      = dir_q ? angle_x - STEP_X : angle_x + STEP_X;
    rev      = dir_q ? angle_x + STEP_X : angle_x - STEP_X;
    wrap     = (fwd > MAX_X) || (fwd < MIN_X);
    angle_nx = wrap ? rev : fwd;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || abort) begin
      dir_q <= 1'b0;
    end else if (advance && wrap) begin
      dir_q <= ~dir_q;
    end
  end
`else
  logic signed [AW:0] fwd;

  always_comb begin
    fwd      = angle_x + STEP_X;
    wrap     = fwd > MAX_X;
    angle_nx = wrap ? MIN_X : fwd;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_in && !stop_in) state_d = LOOKUP;
      end
      LOOKUP:  state_d = stop_in ? IDLE : COMPUTE;
      COMPUTE: state_d = stop_in ? IDLE : EMIT;
      EMIT: begin
        // A pending stop waits for the word on the bus.
        if (accept && (stop_in || stop_pend_q)) begin
          state_d = IDLE;
        end else if (accept && last) begin
          state_d = FIRE;
        end
      end
      FIRE:  state_d = stop_in ? IDLE : DWELL;
      DWELL: begin
        if (stop_in) begin
          state_d = IDLE;
        end else if (dwell_done) begin
          state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      angle_q     <= AW'(ANGLE_MIN);
      sin_q       <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= advance && wrap;
      if (abort) begin
        angle_q <= AW'(ANGLE_MIN);
      end else if (advance) begin
        angle_q <= angle_nx[AW-1:0];
      end
      if (state_q == EMIT && state_d == EMIT) begin
        stop_pend_q <= stop_pend_q || stop_in;
      end else begin
        stop_pend_q <= 1'b0;
      end
      if (state_q == LOOKUP) begin
        sin_q  <= sin_value_in;
        sign_q <= sign_bit_in;
      end
      if (state_q == COMPUTE) begin
        mag_q <= mag_d;
        idx_q <= '0;
        acc_q <= sign_q
               ? DELAY_WIDTH'(mag_d * DELAY_WIDTH'(NUM_ELEMENTS - 1))
               : '0;
      end
      if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
        acc_q <= sign_q ? acc_q - mag_q : acc_q + mag_q;
      end
    end
  end

  dwell_timer #(
    .LIMIT(DWELL_CYCLES)
  ) u_dwell (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load_in (state_q == FIRE),
    .en_in   (state_q == DWELL),
    .done_out(dwell_done)
  );

  assign angle_out         = angle_q;
  assign sweep_angle_out   = angle_q;
  assign delay_out         = acc_q;
  assign delay_idx_out     = idx_q;
  assign delay_valid_out   = state_q == EMIT;
  assign burst_trigger_out = state_q == FIRE;
  assign busy_out          = state_q != IDLE;
  assign sweep_done_out    = done_q;

endmodule

// File: tb/tb_beam_steer_scheduler.sv
// Directed bench: sweep -30..30 step 30, dwell 4, four elements.
// Stimulus driven and outputs sampled on the falling clock edge.
module tb_beam_steer_scheduler;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic              stop_in;
  logic signed [7:0] angle_out;
  logic [15:0]       sin_value_in;
  logic              sign_bit_in;
  logic [15:0]       delay_out;
  logic [1:0]        delay_idx_out;
  logic              delay_valid_out;
  logic              delay_ready_in;
  logic              burst_trigger_out;
  logic signed [7:0] sweep_angle_out;
  logic              busy_out;
  logic              sweep_done_out;

  int checks = 0;
  int errors = 0;

`ifdef BEAM_PINGPONG_EN
  localparam int NEXT_A = 0;
  int exp_nx[4] = '{0, 0, 0, 0};
`else
  localparam int NEXT_A = -30;
  int exp_nx[4] = '{78, 52, 26, 0};
`endif

  always #5 clk_in = ~clk_in;

  // sin_lut values for the angles this sweep visits.
  always_comb begin
    sin_value_in = 16'd0;
    sign_bit_in  = 1'b0;
    case (int'(angle_out))
      30:  sin_value_in = 16'd32768;
      -30: begin
        sin_value_in = 16'd32767;
        sign_bit_in  = 1'b1;
      end
      default: sin_value_in = 16'd0;
    endcase
  end

  beam_steer_scheduler #(
    .NUM_ELEMENTS(4),
    .ANGLE_WIDTH (8),
    .SIN_WIDTH   (16),
    .DELAY_WIDTH (16),
    .PITCH_CYCLES(54),
    .ANGLE_MIN   (-30),
    .ANGLE_MAX   (30),
    .ANGLE_STEP  (30),
    .DWELL_CYCLES(4)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .stop_in          (stop_in),
    .angle_out        (angle_out),
    .sin_value_in     (sin_value_in),
    .sign_bit_in      (sign_bit_in),
    .delay_out        (delay_out),
    .delay_idx_out    (delay_idx_out),
    .delay_valid_out  (delay_valid_out),
    .delay_ready_in   (delay_ready_in),
    .burst_trigger_out(burst_trigger_out),
    .sweep_angle_out  (sweep_angle_out),
    .busy_out         (busy_out),
    .sweep_done_out   (sweep_done_out)
  );

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic get_words(output int d[4], output int n);
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (delay_valid_out && delay_ready_in) begin
        d[n] = int'(delay_out);
        n++;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output int dones, output int dang);
    dones = 0;
    dang  = 999;
    for (int c = 0; c < 40 && !delay_valid_out; c++) begin
      if (sweep_done_out) begin
        dones++;
        dang = int'(angle_out);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    start_in = 1'b0;
    stop_in = 1'b0;
    delay_ready_in = 1'b1;
    tick();
    tick();
    checks++;
    if (angle_out !== -30 || sweep_angle_out !== -30 ||
        busy_out !== 1'b0 || delay_valid_out !== 1'b0 ||
        delay_out !== 16'd0 || delay_idx_out !== 2'd0 ||
        burst_trigger_out !== 1'b0 || sweep_done_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: ang=%0d busy=%b vld=%b dly=%0d bst=%b dn=%b, required ang=-30 rest 0",
               angle_out, busy_out, delay_valid_out, delay_out,
               burst_trigger_out, sweep_done_out);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_first_angle();
    int d[4];
    int n;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || delay_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL lookup: busy=%b vld=%b, required 1 0",
               busy_out, delay_valid_out);
    end
    tick();
    checks++;
    if (delay_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL compute_valid: got %b, required 0", delay_valid_out);
    end
    tick();
    checks++;
    if (delay_valid_out !== 1'b1 || angle_out !== -30) begin
      errors++;
      $display("FAIL latency: vld=%b ang=%0d, required 1 -30",
               delay_valid_out, angle_out);
    end
    get_words(d, n);
    checks++;
    if (n != 4 || d[0] != 78 || d[1] != 52 || d[2] != 26 || d[3] != 0) begin
      errors++;
      $display("FAIL words_m30: n=%0d %0d,%0d,%0d,%0d, required 4 78,52,26,0",
               n, d[0], d[1], d[2], d[3]);
    end
    checks++;
    if (burst_trigger_out !== 1'b1) begin
      errors++;
      $display("FAIL burst_on: got %b, required 1", burst_trigger_out);
    end
    tick();
    checks++;
    if (burst_trigger_out !== 1'b0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL burst_width: bst=%b busy=%b, required 0 1",
               burst_trigger_out, busy_out);
    end
  endtask

  task automatic test_sweep();
    int d[4];
    int n;
    int dn;
    int da;
    wait_valid(dn, da);
    checks++;
    if (delay_valid_out !== 1'b1 || angle_out !== 0 || dn != 0) begin
      errors++;
      $display("FAIL step_0: vld=%b ang=%0d dones=%0d, required 1 0 0",
               delay_valid_out, angle_out, dn);
    end
    get_words(d, n);
    checks++;
    if (n != 4 || d[0] != 0 || d[1] != 0 || d[2] != 0 || d[3] != 0) begin
      errors++;
      $display("FAIL words_0: n=%0d %0d,%0d,%0d,%0d, required 4 0,0,0,0",
               n, d[0], d[1], d[2], d[3]);
    end
    wait_valid(dn, da);
    checks++;
    if (delay_valid_out !== 1'b1 || sweep_angle_out !== 30 || dn != 0) begin
      errors++;
      $display("FAIL step_30: vld=%b ang=%0d dones=%0d, required 1 30 0",
               delay_valid_out, sweep_angle_out, dn);
    end
    get_words(d, n);
    checks++;
    if (n != 4 || d[0] != 0 || d[1] != 27 || d[2] != 54 || d[3] != 81) begin
      errors++;
      $display("FAIL words_30: n=%0d %0d,%0d,%0d,%0d, required 4 0,27,54,81",
               n, d[0], d[1], d[2], d[3]);
    end
    wait_valid(dn, da);
    checks++;
    if (delay_valid_out !== 1'b1 || dn != 1 || da != NEXT_A ||
        angle_out !== NEXT_A) begin
      errors++;
      $display("FAIL wrap: vld=%b dones=%0d at %0d ang=%0d, required 1 1 at %0d",
               delay_valid_out, dn, da, angle_out, NEXT_A);
    end
  endtask

  task automatic test_back_pressure();
    int hold_d;
    int bad;
    tick();
    delay_ready_in = 1'b0;
    hold_d = int'(delay_out);
    checks++;
    if (delay_idx_out !== 2'd1 || hold_d != exp_nx[1]) begin
      errors++;
      $display("FAIL bp_first: idx=%0d dly=%0d, required 1 %0d",
               delay_idx_out, hold_d, exp_nx[1]);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (delay_valid_out !== 1'b1 || delay_idx_out !== 2'd1 ||
          int'(delay_out) != hold_d)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    delay_ready_in = 1'b1;
    tick();
    checks++;
    if (delay_idx_out !== 2'd2 || int'(delay_out) != exp_nx[2]) begin
      errors++;
      $display("FAIL bp_next: idx=%0d dly=%0d, required 2 %0d",
               delay_idx_out, delay_out, exp_nx[2]);
    end
    tick();
    tick();
    checks++;
    if (burst_trigger_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_burst: got %b, required 1", burst_trigger_out);
    end
  endtask

  task automatic test_stop_dwell();
    tick();
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || angle_out !== -30) begin
      errors++;
      $display("FAIL stop_dwell: busy=%b ang=%0d, required 0 -30",
               busy_out, angle_out);
    end
  endtask

  task automatic test_start_stop_same();
    start_in = 1'b1;
    stop_in = 1'b1;
    tick();
    start_in = 1'b0;
    stop_in = 1'b0;
    tick();
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: busy=%b, required 0", busy_out);
    end
  endtask

  task automatic test_stop_emit();
    int dn;
    int da;
    int bad;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(dn, da);
    delay_ready_in = 1'b0;
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (delay_valid_out !== 1'b1 || delay_idx_out !== 2'd0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop_emit_hold: %0d bad cycles, required 0", bad);
    end
    delay_ready_in = 1'b1;
    tick();
    checks++;
    if (busy_out !== 1'b0 || delay_valid_out !== 1'b0 ||
        burst_trigger_out !== 1'b0 || angle_out !== -30) begin
      errors++;
      $display("FAIL stop_emit: busy=%b vld=%b bst=%b ang=%0d, required 0 0 0 -30",
               busy_out, delay_valid_out, burst_trigger_out, angle_out);
    end
  endtask

  task automatic test_reset_mid_emit();
    int dn;
    int da;
    int d[4];
    int n;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(dn, da);
    tick();
    rst_in = 1'b1;
    tick();
    checks++;
    if (busy_out !== 1'b0 || delay_valid_out !== 1'b0 ||
        delay_out !== 16'd0 || delay_idx_out !== 2'd0 ||
        burst_trigger_out !== 1'b0 || sweep_done_out !== 1'b0 ||
        angle_out !== -30) begin
      errors++;
      $display("FAIL rst_emit: busy=%b vld=%b dly=%0d idx=%0d ang=%0d, required reset values",
               busy_out, delay_valid_out, delay_out, delay_idx_out, angle_out);
    end
    rst_in = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(dn, da);
    get_words(d, n);
    checks++;
    if (n != 4 || d[0] != 78 || d[3] != 0 || burst_trigger_out !== 1'b1) begin
      errors++;
      $display("FAIL restart: n=%0d d0=%0d d3=%0d bst=%b, required 4 78 0 1",
               n, d[0], d[3], burst_trigger_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_angle();
    test_sweep();
    test_back_pressure();
    test_stop_dwell();
    test_start_stop_same();
    test_stop_emit();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
